ysyx_22051013_icache_ctrl: RTL and testbench

Controller FSM for the direct-mapped 32-set instruction cache. It sequences the 1-cycle synchronous tag RAM (25-bit entry: valid + 24-bit tag) and a matching 32x64 data RAM. It accepts fetch requests, performs the lookup, and runs the miss refill over a valid/ready memory port. It also sweeps all valid bits to 0 after reset and on fence_i.

---
 rtl/ysyx_22051013_icache_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ysyx_22051013_icache_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22051013_icache_ctrl.sv
// Controller FSM for a direct-mapped instruction cache.
// Sequences a 1-cycle synchronous tag RAM ({valid, tag}) and a matching data RAM,
// performs lookups for fetch requests, refills misses over a valid/ready memory
// port, and sweeps every valid bit to 0 after reset and on fence_i.
// Optional macro YSYX_22051013_ICACHE_PERF_CNT_EN adds hit_cnt / miss_cnt outputs.
module ysyx_22051013_icache_ctrl #(
  parameter int SETS  = 32,
  parameter int TAG_W = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fence_i,
  input  logic                     cpu_req_valid,
  input  logic [31:0]              cpu_req_addr,
  output logic                     cpu_req_ready,
  output logic                     cpu_resp_valid,
  output logic [63:0]              cpu_resp_data,
  output logic [$clog2(SETS)-1:0]  tag_addr,
  output logic [TAG_W:0]           tag_wdata,
  output logic                     tag_we,
  input  logic [TAG_W-1:0]         tag_rdata,
  input  logic                     tag_valid,
  output logic [$clog2(SETS)-1:0]  data_addr,
  output logic [63:0]              data_wdata,
  output logic                     data_we,
  input  logic [63:0]              data_rdata,
  output logic                     mem_req_valid,
  output logic [31:0]              mem_req_addr,
  input  logic                     mem_req_ready,
  input  logic                     mem_resp_valid,
  input  logic [63:0]              mem_resp_data
`ifdef YSYX_22051013_ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]              hit_cnt,
  output logic [31:0]              miss_cnt
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int IDX_LO = 3;
  localparam int IDX_HI = IDX_LO + IDX_W - 1;
  localparam int TAG_LO = 32 - TAG_W;

  typedef enum logic [2:0] {
    INVAL     = 3'd0,
    IDLE      = 3'd1,
    LOOKUP    = 3'd2,
    MISS_REQ  = 3'd3,
    MISS_WAIT = 3'd4
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] cnt;
  logic [31:0]      addr_q;
  logic             fence_pend;
  logic             hit;

  // Byte offset within the line never matters to the controller.
  logic unused_offset;
  assign unused_offset = ^addr_q[2:0];

  assign hit       = tag_valid && (tag_rdata == addr_q[31:TAG_LO]);
  assign data_addr = tag_addr;

  // Output decode; everything is held at 0 while reset is asserted.
  always_comb begin
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_data  = '0;
    tag_addr       = '0;
    tag_wdata      = '0;
    tag_we         = 1'b0;
    data_wdata     = '0;
    data_we        = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_addr   = '0;
    if (rst_n) begin
      case (state)
        INVAL: begin
          tag_addr = cnt;
          tag_we   = 1'b1;
        end
        IDLE: begin
          cpu_req_ready = !(fence_pend || fence_i);
          tag_addr      = cpu_req_addr[IDX_HI:IDX_LO];
        end
        LOOKUP: begin
          tag_addr = addr_q[IDX_HI:IDX_LO];
          if (hit) begin
            cpu_resp_valid = 1'b1;
            cpu_resp_data  = data_rdata;
          end
        end
        MISS_REQ: begin
          tag_addr      = addr_q[IDX_HI:IDX_LO];
          mem_req_valid = 1'b1;
          mem_req_addr  = {addr_q[31:3], 3'b000};
        end
        MISS_WAIT: begin
          tag_addr = addr_q[IDX_HI:IDX_LO];
          if (mem_resp_valid) begin
            tag_we         = 1'b1;
            tag_wdata      = {1'b1, addr_q[31:TAG_LO]};
            data_we        = 1'b1;
            data_wdata     = mem_resp_data;
            cpu_resp_valid = 1'b1;
            cpu_resp_data  = mem_resp_data;
          end
        end
        default: ;
      endcase
    end
  end

  // State, sweep counter, captured address, deferred fence and perf counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INVAL;
      cnt        <= '0;
      addr_q     <= '0;
      fence_pend <= 1'b0;
`ifdef YSYX_22051013_ICACHE_PERF_CNT_EN
      hit_cnt    <= '0;
      miss_cnt   <= '0;
`endif
    end else begin
      case (state)
        INVAL: begin
          // fence_i here is redundant: the sweep already clears everything.
          fence_pend <= 1'b0;
          cnt        <= cnt + 1'b1;
          if (cnt == IDX_W'(SETS - 1)) state <= IDLE;
        end
        IDLE: begin
          if (fence_pend || fence_i) begin
            state      <= INVAL;
            cnt        <= '0;
            fence_pend <= 1'b0;
          end else if (cpu_req_valid) begin
            addr_q <= cpu_req_addr;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (fence_i) fence_pend <= 1'b1;
          if (hit) begin
            state <= IDLE;
`ifdef YSYX_22051013_ICACHE_PERF_CNT_EN
            hit_cnt <= hit_cnt + 32'd1;
`endif
          end else begin
            state <= MISS_REQ;
`ifdef YSYX_22051013_ICACHE_PERF_CNT_EN
            miss_cnt <= miss_cnt + 32'd1;
`endif
          end
        end
        MISS_REQ: begin
          if (fence_i) fence_pend <= 1'b1;
          if (mem_req_ready) state <= MISS_WAIT;
        end
        MISS_WAIT: begin
          if (fence_i) fence_pend <= 1'b1;
          if (mem_resp_valid) state <= IDLE;
        end
        default: state <= INVAL;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22051013_icache_ctrl.sv
// Directed testbench for ysyx_22051013_icache_ctrl with behavioural tag/data RAMs.
module tb_ysyx_22051013_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fence_i;
  logic        cpu_req_valid;
  logic [31:0] cpu_req_addr;
  logic        cpu_req_ready;
  logic        cpu_resp_valid;
  logic [63:0] cpu_resp_data;
  logic [4:0]  tag_addr;
  logic [24:0] tag_wdata;
  logic        tag_we;
  logic [23:0] tag_rdata;
  logic        tag_valid;
  logic [4:0]  data_addr;
  logic [63:0] data_wdata;
  logic        data_we;
  logic [63:0] data_rdata;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
`ifdef YSYX_22051013_ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22051013_icache_ctrl dut (
    .clk(clk), .rst_n(rst_n), .fence_i(fence_i),
    .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr),
    .cpu_req_ready(cpu_req_ready), .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_data(cpu_resp_data),
    .tag_addr(tag_addr), .tag_wdata(tag_wdata), .tag_we(tag_we),
    .tag_rdata(tag_rdata), .tag_valid(tag_valid),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_we(data_we),
    .data_rdata(data_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data)
`ifdef YSYX_22051013_ICACHE_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  // Behavioural synchronous RAMs, read-before-write. Tag RAM starts full of
  // valid entries for tag 0x800000 so a skipped sweep would show up as a false hit.
  logic [24:0] tmem [32];
  logic [63:0] dmem [32];
  logic [24:0] trd;
  initial begin
    for (int i = 0; i < 32; i++) begin
      tmem[i] = 25'h1800000;
      dmem[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
    end
    trd = '0;
    data_rdata = '0;
  end
  always @(posedge clk) begin
    trd        <= tmem[tag_addr];
    data_rdata <= dmem[data_addr];
    if (tag_we)  tmem[tag_addr]  <= tag_wdata;
    if (data_we) dmem[data_addr] <= data_wdata;
  end
  assign tag_valid = trd[24];
  assign tag_rdata = trd[23:0];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge, where inputs are changed; checks follow #1 later.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; fence_i = 1'b0; cpu_req_valid = 1'b0; cpu_req_addr = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;

    // Reset: all outputs low
    step(); step(); #1;
    chk("rst_tag_we", 64'(tag_we), 0);
    chk("rst_ready", 64'(cpu_req_ready), 0);
    chk("rst_mem_req", 64'(mem_req_valid), 0);
    chk("rst_resp", 64'(cpu_resp_valid), 0);
    $display("txn reset: outputs low");

    // Test 1: 32-cycle sweep after release
    step(); rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("sweep_we", 64'(tag_we), 1);
      chk("sweep_addr", 64'(tag_addr), 64'(i));
      chk("sweep_wdata", 64'(tag_wdata), 0);
      chk("sweep_ready", 64'(cpu_req_ready), 0);
      step();
    end
    #1;
    chk("sweep_done_ready", 64'(cpu_req_ready), 1);
    chk("sweep_done_we", 64'(tag_we), 0);
    $display("txn sweep: 32 cycles");

    // Test 2: cold miss on 0x8000_0010
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h8000_0010; #1;
    chk("t2_idx", 64'(tag_addr), 2);
    step(); cpu_req_valid = 1'b0; #1;
    chk("t2_lookup_resp", 64'(cpu_resp_valid), 0);
    step(); mem_req_ready = 1'b1; #1;
    chk("t2_mreq_valid", 64'(mem_req_valid), 1);
    chk("t2_mreq_addr", 64'(mem_req_addr), 64'h8000_0010);
    step(); mem_req_ready = 1'b0; #1;
    chk("t2_wait_resp", 64'(cpu_resp_valid), 0);
    step(); mem_resp_valid = 1'b1; mem_resp_data = 64'h1122334455667788; #1;
    chk("t2_tag_we", 64'(tag_we), 1);
    chk("t2_tag_wdata", 64'(tag_wdata), 64'h1800000);
    chk("t2_tag_addr", 64'(tag_addr), 2);
    chk("t2_data_we", 64'(data_we), 1);
    chk("t2_data_wdata", 64'(data_wdata), 64'h1122334455667788);
    chk("t2_resp_valid", 64'(cpu_resp_valid), 1);
    chk("t2_resp_data", cpu_resp_data, 64'h1122334455667788);
    step(); mem_resp_valid = 1'b0; #1;
    chk("t2_idle_resp", 64'(cpu_resp_valid), 0);
    chk("t2_idle_ready", 64'(cpu_req_ready), 1);
    $display("txn fetch 80000010: miss refill");

    // Test 3: hit on 0x8000_0014
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h8000_0014;
    step(); cpu_req_valid = 1'b0; #1;
    chk("t3_hit_valid", 64'(cpu_resp_valid), 1);
    chk("t3_hit_data", cpu_resp_data, 64'h1122334455667788);
    chk("t3_no_mreq", 64'(mem_req_valid), 0);
    step(); #1;
    chk("t3_idle_no_mreq", 64'(mem_req_valid), 0);
    chk("t3_idle_resp", 64'(cpu_resp_valid), 0);
`ifdef YSYX_22051013_ICACHE_PERF_CNT_EN
    chk("t3_hit_cnt", 64'(hit_cnt), 1);
    chk("t3_miss_cnt", 64'(miss_cnt), 1);
`endif
    $display("txn fetch 80000014: hit");

    // Test 4: conflict miss 0x9000_0010 with stalled mem_req_ready
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h8000_0010;
    step(); cpu_req_valid = 1'b0; #1;
    chk("t4_hit_a", 64'(cpu_resp_valid), 1);
    step(); cpu_req_valid = 1'b1; cpu_req_addr = 32'h9000_0010;
    step(); cpu_req_valid = 1'b0; #1;
    chk("t4_conflict_miss", 64'(cpu_resp_valid), 0);
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      chk("t4_stall_valid", 64'(mem_req_valid), 1);
      chk("t4_stall_addr", 64'(mem_req_addr), 64'h9000_0010);
    end
    step(); mem_req_ready = 1'b1; #1;
    chk("t4_mreq_addr", 64'(mem_req_addr), 64'h9000_0010);
    step(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'hAAAA_BBBB_CCCC_DDDD; #1;
    chk("t4_tag_wdata", 64'(tag_wdata), 64'h1900000);
    chk("t4_resp_data", cpu_resp_data, 64'hAAAA_BBBB_CCCC_DDDD);
    step(); mem_resp_valid = 1'b0; cpu_req_valid = 1'b1; cpu_req_addr = 32'h8000_0010;
    step(); cpu_req_valid = 1'b0; #1;
    chk("t4_refetch_miss", 64'(cpu_resp_valid), 0);
    step(); mem_req_ready = 1'b1; #1;
    chk("t4_refetch_mreq", 64'(mem_req_addr), 64'h8000_0010);
    step(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h1122334455667788; #1;
    chk("t4_refill_resp", 64'(cpu_resp_valid), 1);
    step(); mem_resp_valid = 1'b0;
    $display("txn conflict 90000010 / 80000010: both miss");

    // Test 5: fence_i during MISS_WAIT
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h8800_0010;
    step(); cpu_req_valid = 1'b0; #1;
    chk("t5_miss", 64'(cpu_resp_valid), 0);
    step(); mem_req_ready = 1'b1;
    step(); mem_req_ready = 1'b0; fence_i = 1'b1; #1;
    chk("t5_wait_resp", 64'(cpu_resp_valid), 0);
    step(); fence_i = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h0123_4567_89AB_CDEF; #1;
    chk("t5_resp_valid", 64'(cpu_resp_valid), 1);
    chk("t5_resp_data", cpu_resp_data, 64'h0123_4567_89AB_CDEF);
    step(); mem_resp_valid = 1'b0; cpu_req_valid = 1'b1; cpu_req_addr = 32'h8800_0010; #1;
    chk("t5_pend_ready", 64'(cpu_req_ready), 0);
    chk("t5_pend_we", 64'(tag_we), 0);
    step(); cpu_req_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("t5_sweep_we", 64'(tag_we), 1);
      chk("t5_sweep_addr", 64'(tag_addr), 64'(i));
      step();
    end
    #1;
    chk("t5_after_ready", 64'(cpu_req_ready), 1);
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h8000_0010;
    step(); cpu_req_valid = 1'b0; #1;
    chk("t5_post_fence_miss", 64'(cpu_resp_valid), 0);
    step(); mem_req_ready = 1'b1; #1;
    chk("t5_post_fence_mreq", 64'(mem_req_valid), 1);
    $display("txn fence during refill: sweep, then miss");

    // Test 6: reset mid-refill, stale beat during INVAL
    step(); mem_req_ready = 1'b0; rst_n = 1'b0; #1;
    chk("t6_rst_resp", 64'(cpu_resp_valid), 0);
    chk("t6_rst_mreq", 64'(mem_req_valid), 0);
    step(); rst_n = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 64'hFFFF_0000_FFFF_0000; #1;
    chk("t6_stale_wdata", 64'(tag_wdata), 0);
    chk("t6_stale_resp", 64'(cpu_resp_valid), 0);
    chk("t6_stale_data_we", 64'(data_we), 0);
    step(); mem_resp_valid = 1'b0;
    for (int i = 1; i < 32; i++) step();
    #1;
    chk("t6_ready", 64'(cpu_req_ready), 1);
`ifdef YSYX_22051013_ICACHE_PERF_CNT_EN
    chk("t6_hit_cnt_rst", 64'(hit_cnt), 0);
`endif
    $display("txn reset mid-refill: stale beat ignored");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
